// File: rtl/hssi_lane_reset_seq.sv
// hssi_lane_reset_seq: AFU-side bring-up and reset sequencer for HSSI lanes.
// Handshakes GBS init with the FIU, sequences TX then RX analog/digital resets
// against calibration and lock status, reports link_up, recovers the RX path
// on loss of lock and escalates repeated timeouts to fatal_err.
// Optional feature macro: HSSI_RST_SEQ_STATS_EN adds the lol_cnt and
// retry_total statistics outputs.
module hssi_lane_reset_seq #(
    parameter int NUM_LN      = 4,
    parameter int ANA_RST_CYC = 256,
    parameter int DIG_RST_CYC = 64,
    parameter int STABLE_CYC  = 1024,
    parameter int TIMEOUT_CYC = 2**20,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_start,
    output logic              init_start,
    input  logic              init_done,
    input  logic              tx_cal_busy,
    input  logic              tx_pll_locked,
    input  logic              rx_cal_busy,
    input  logic [NUM_LN-1:0] rx_is_lockedtodata,
    output logic [NUM_LN-1:0] tx_analogreset,
    output logic [NUM_LN-1:0] tx_digitalreset,
    output logic [NUM_LN-1:0] rx_analogreset,
    output logic [NUM_LN-1:0] rx_digitalreset,
    output logic [NUM_LN-1:0] rx_set_locktoref,
    output logic [NUM_LN-1:0] rx_set_locktodata,
    output logic              link_up,
    output logic              fatal_err,
    output logic [3:0]        state_dbg
`ifdef HSSI_RST_SEQ_STATS_EN
    ,
    output logic [15:0]       lol_cnt,
    output logic [7:0]        retry_total
`endif
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT    = 4'd1;
    localparam logic [3:0] S_TX_ANA  = 4'd2;
    localparam logic [3:0] S_TX_WAIT = 4'd3;
    localparam logic [3:0] S_TX_DIG  = 4'd4;
    localparam logic [3:0] S_RX_ANA  = 4'd5;
    localparam logic [3:0] S_RX_WAIT = 4'd6;
    localparam logic [3:0] S_RX_LOCK = 4'd7;
    localparam logic [3:0] S_RX_DIG  = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;
    localparam logic [3:0] S_FAIL    = 4'd10;

    // One counter width covers every hold, stability and timeout count.
    localparam int MAX_A   = (TIMEOUT_CYC > STABLE_CYC) ? TIMEOUT_CYC : STABLE_CYC;
    localparam int MAX_B   = (ANA_RST_CYC > DIG_RST_CYC) ? ANA_RST_CYC : DIG_RST_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] ANA_LAST    = CNT_W'(ANA_RST_CYC - 1);
    localparam logic [CNT_W-1:0] DIG_LAST    = CNT_W'(DIG_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
    localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_stable;
    logic [RTY_W-1:0]  r_retry;
    logic [NUM_LN+3:0] r_meta;
    logic [NUM_LN+3:0] r_sync;
    logic              w_init_done_s;
    logic              w_tx_cal_busy_s;
    logic              w_tx_pll_locked_s;
    logic              w_rx_cal_busy_s;
    logic              w_all_locked;
    logic              w_tmo;
    logic              w_timeout_ev;
    logic              w_lol_ev;

    logic              r_init_start, w_init_start;
    logic              r_link_up, w_link_up;
    logic              r_fatal_err, w_fatal_err;
    logic [NUM_LN-1:0] r_tx_ana, w_tx_ana;
    logic [NUM_LN-1:0] r_tx_dig, w_tx_dig;
    logic [NUM_LN-1:0] r_rx_ana, w_rx_ana;
    logic [NUM_LN-1:0] r_rx_dig, w_rx_dig;

    // Two-flop synchronizer for every FIU status input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {init_done, tx_cal_busy, tx_pll_locked, rx_cal_busy, rx_is_lockedtodata};
            r_sync <= r_meta;
        end
    end

    assign w_init_done_s     = r_sync[NUM_LN+3];
    assign w_tx_cal_busy_s   = r_sync[NUM_LN+2];
    assign w_tx_pll_locked_s = r_sync[NUM_LN+1];
    assign w_rx_cal_busy_s   = r_sync[NUM_LN];
    assign w_all_locked      = &r_sync[NUM_LN-1:0];
    assign w_tmo             = (r_cnt == TMO_LAST);

    // Next-state logic; exit conditions beat timeouts, req_start=0 beats everything.
    always_comb begin
        w_next       = r_state;
        w_timeout_ev = 1'b0;
        w_lol_ev     = 1'b0;
        case (r_state)
            S_IDLE:    w_next = S_INIT;
            S_INIT:    if (w_init_done_s) w_next = S_TX_ANA;
                       else if (w_tmo) w_timeout_ev = 1'b1;
            S_TX_ANA:  if (r_cnt == ANA_LAST) w_next = S_TX_WAIT;
            S_TX_WAIT: if (!w_tx_cal_busy_s && w_tx_pll_locked_s) w_next = S_TX_DIG;
                       else if (w_tmo) w_timeout_ev = 1'b1;
            S_TX_DIG:  if (r_cnt == DIG_LAST) w_next = S_RX_ANA;
            S_RX_ANA:  if (r_cnt == ANA_LAST) w_next = S_RX_WAIT;
            S_RX_WAIT: if (!w_rx_cal_busy_s) w_next = S_RX_LOCK;
                       else if (w_tmo) w_timeout_ev = 1'b1;
            S_RX_LOCK: if (w_all_locked && (r_stable == STABLE_LAST)) w_next = S_RX_DIG;
                       else if (w_tmo) w_timeout_ev = 1'b1;
            S_RX_DIG:  if (r_cnt == DIG_LAST) w_next = S_DONE;
            S_DONE:    if (!w_all_locked) begin
                           w_next   = S_RX_ANA;
                           w_lol_ev = 1'b1;
                       end
            S_FAIL:    w_next = S_FAIL;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout_ev) begin
            w_next = (r_retry < RTY_MAX) ? S_TX_ANA : S_FAIL;
        end
        if (!req_start) begin
            w_next       = S_IDLE;
            w_timeout_ev = 1'b0;
            w_lol_ev     = 1'b0;
        end
    end

    // Output decode of the next state so registered outputs line up with r_state.
    always_comb begin
        w_init_start = 1'b0;
        w_link_up    = 1'b0;
        w_fatal_err  = 1'b0;
        w_tx_ana     = '1;
        w_tx_dig     = '1;
        w_rx_ana     = '1;
        w_rx_dig     = '1;
        case (w_next)
            S_INIT:                       w_init_start = 1'b1;
            S_TX_WAIT, S_TX_DIG:          w_tx_ana = '0;
            S_RX_ANA: begin
                w_tx_ana = '0;
                w_tx_dig = '0;
            end
            S_RX_WAIT, S_RX_LOCK, S_RX_DIG: begin
                w_tx_ana = '0;
                w_tx_dig = '0;
                w_rx_ana = '0;
            end
            S_DONE: begin
                w_tx_ana  = '0;
                w_tx_dig  = '0;
                w_rx_ana  = '0;
                w_rx_dig  = '0;
                w_link_up = 1'b1;
            end
            S_FAIL:                       w_fatal_err = 1'b1;
            default:                      w_init_start = 1'b0;
        endcase
    end

    // State, counters, retry budget and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_stable     <= '0;
            r_retry      <= '0;
            r_init_start <= 1'b0;
            r_link_up    <= 1'b0;
            r_fatal_err  <= 1'b0;
            r_tx_ana     <= '1;
            r_tx_dig     <= '1;
            r_rx_ana     <= '1;
            r_rx_dig     <= '1;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state entry and saturates otherwise.
            if (w_next != r_state) r_cnt <= '0;
            else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
            // Consecutive all-lanes-locked cycles, only meaningful in RX_LOCK.
            if (r_state != S_RX_LOCK || !w_all_locked) r_stable <= '0;
            else if (r_stable != CNT_SAT) r_stable <= r_stable + 1'b1;
            // A fresh start from IDLE also gets the full retry budget back.
            if (r_state == S_DONE || r_state == S_IDLE) r_retry <= '0;
            else if (w_timeout_ev && (r_retry < RTY_MAX)) r_retry <= r_retry + 1'b1;
            r_init_start <= w_init_start;
            r_link_up    <= w_link_up;
            r_fatal_err  <= w_fatal_err;
            r_tx_ana     <= w_tx_ana;
            r_tx_dig     <= w_tx_dig;
            r_rx_ana     <= w_rx_ana;
            r_rx_dig     <= w_rx_dig;
        end
    end

    assign init_start        = r_init_start;
    assign link_up           = r_link_up;
    assign fatal_err         = r_fatal_err;
    assign tx_analogreset    = r_tx_ana;
    assign tx_digitalreset   = r_tx_dig;
    assign rx_analogreset    = r_rx_ana;
    assign rx_digitalreset   = r_rx_dig;
    assign rx_set_locktoref  = '0;
    assign rx_set_locktodata = '0;
    assign state_dbg         = r_state;

`ifdef HSSI_RST_SEQ_STATS_EN
    logic [15:0] r_lol_cnt;
    logic [7:0]  r_retry_total;

    // Saturating event statistics, cleared only by rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lol_cnt     <= '0;
            r_retry_total <= '0;
        end else begin
            if (w_lol_ev && (r_lol_cnt != 16'hFFFF)) r_lol_cnt <= r_lol_cnt + 16'd1;
            if (w_timeout_ev && (r_retry_total != 8'hFF)) r_retry_total <= r_retry_total + 8'd1;
        end
    end

    assign lol_cnt     = r_lol_cnt;
    assign retry_total = r_retry_total;
`endif

endmodule

// File: tb/tb_hssi_lane_reset_seq.sv
// Directed bench for hssi_lane_reset_seq with small timing parameters.
// Optional feature macro: HSSI_RST_SEQ_STATS_EN enables the statistics checks.
module tb_hssi_lane_reset_seq;

    localparam int NUM_LN = 4;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT    = 4'd1;
    localparam logic [3:0] S_TX_ANA  = 4'd2;
    localparam logic [3:0] S_TX_WAIT = 4'd3;
    localparam logic [3:0] S_TX_DIG  = 4'd4;
    localparam logic [3:0] S_RX_ANA  = 4'd5;
    localparam logic [3:0] S_RX_WAIT = 4'd6;
    localparam logic [3:0] S_RX_LOCK = 4'd7;
    localparam logic [3:0] S_RX_DIG  = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;
    localparam logic [3:0] S_FAIL    = 4'd10;

    // {init_start, link_up, fatal_err, tx_ana, tx_dig, rx_ana, rx_dig}
    localparam logic [18:0] O_IDLE = {3'b000, 16'hFFFF};
    localparam logic [18:0] O_INIT = {3'b100, 16'hFFFF};
    localparam logic [18:0] O_TXA  = {3'b000, 16'hFFFF};
    localparam logic [18:0] O_TXW  = {3'b000, 16'h0FFF};
    localparam logic [18:0] O_RXA  = {3'b000, 16'h00FF};
    localparam logic [18:0] O_RXW  = {3'b000, 16'h000F};
    localparam logic [18:0] O_DONE = {3'b010, 16'h0000};
    localparam logic [18:0] O_FAIL = {3'b001, 16'hFFFF};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_start;
    logic              init_start;
    logic              init_done;
    logic              tx_cal_busy;
    logic              tx_pll_locked;
    logic              rx_cal_busy;
    logic [NUM_LN-1:0] rx_is_lockedtodata;
    logic [NUM_LN-1:0] tx_analogreset;
    logic [NUM_LN-1:0] tx_digitalreset;
    logic [NUM_LN-1:0] rx_analogreset;
    logic [NUM_LN-1:0] rx_digitalreset;
    logic [NUM_LN-1:0] rx_set_locktoref;
    logic [NUM_LN-1:0] rx_set_locktodata;
    logic              link_up;
    logic              fatal_err;
    logic [3:0]        state_dbg;
`ifdef HSSI_RST_SEQ_STATS_EN
    logic [15:0]       lol_cnt;
    logic [7:0]        retry_total;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [22:0] exp_v;
    logic [22:0] w_obs;

    assign w_obs = {state_dbg, init_start, link_up, fatal_err,
                    tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset};

    hssi_lane_reset_seq #(
        .NUM_LN(NUM_LN), .ANA_RST_CYC(8), .DIG_RST_CYC(4),
        .STABLE_CYC(16), .TIMEOUT_CYC(200), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_start(req_start), .init_start(init_start),
        .init_done(init_done), .tx_cal_busy(tx_cal_busy), .tx_pll_locked(tx_pll_locked),
        .rx_cal_busy(rx_cal_busy), .rx_is_lockedtodata(rx_is_lockedtodata),
        .tx_analogreset(tx_analogreset), .tx_digitalreset(tx_digitalreset),
        .rx_analogreset(rx_analogreset), .rx_digitalreset(rx_digitalreset),
        .rx_set_locktoref(rx_set_locktoref), .rx_set_locktodata(rx_set_locktodata),
        .link_up(link_up), .fatal_err(fatal_err), .state_dbg(state_dbg)
`ifdef HSSI_RST_SEQ_STATS_EN
        , .lol_cnt(lol_cnt), .retry_total(retry_total)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Advance n cycles and settle 1ns past the edge for driving and sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_start = 1'b0; init_done = 1'b0; tx_cal_busy = 1'b0;
        tx_pll_locked = 1'b1; rx_cal_busy = 1'b0; rx_is_lockedtodata = 4'hF;
        tick(3);
        exp_v = {S_IDLE, O_IDLE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL reset_state: got %h exp %h", w_obs, exp_v); else n_pass++;
        n_chk++;
        if ({rx_set_locktoref, rx_set_locktodata} !== 8'h00)
            $display("FAIL cdr_consts: got %h exp 00", {rx_set_locktoref, rx_set_locktodata});
        else n_pass++;
        rst_n = 1'b1;
        tick(3);
        exp_v = {S_IDLE, O_IDLE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL idle_no_req: got %h exp %h", w_obs, exp_v); else n_pass++;
    endtask

    task automatic test_nominal;
        req_start = 1'b1;
        tick(1);
        exp_v = {S_INIT, O_INIT}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_init: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(9);
        init_done = 1'b1;
        tick(2);
        exp_v = {S_INIT, O_INIT}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_init_sync: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_TX_ANA, O_TXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_tx_ana: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(7);
        exp_v = {S_TX_ANA, O_TXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_tx_ana_hold: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_TX_WAIT, O_TXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_tx_wait: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_TX_DIG, O_TXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_tx_dig: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(3);
        exp_v = {S_TX_DIG, O_TXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_tx_dig_hold: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_RX_ANA, O_RXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_rx_ana: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(8);
        exp_v = {S_RX_WAIT, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_rx_wait: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_RX_LOCK, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_rx_lock: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(15);
        exp_v = {S_RX_LOCK, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_rx_lock_hold: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_RX_DIG, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_rx_dig: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(3);
        exp_v = {S_RX_DIG, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_rx_dig_hold: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_DONE, O_DONE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL nom_done: got %h exp %h", w_obs, exp_v); else n_pass++;
    endtask

    task automatic test_lol_glitch;
        rx_is_lockedtodata = 4'b1110;
        tick(2);
        exp_v = {S_DONE, O_DONE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL lol_sync_delay: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_RX_ANA, O_RXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL lol_rx_ana: got %h exp %h", w_obs, exp_v); else n_pass++;
        rx_is_lockedtodata = 4'hF;
        tick(9);
        exp_v = {S_RX_LOCK, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL lol_rx_lock: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(8);
        rx_is_lockedtodata = 4'b1011;
        tick(1);
        rx_is_lockedtodata = 4'hF;
        tick(17);
        exp_v = {S_RX_LOCK, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL glitch_restart: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_RX_DIG, O_RXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL glitch_rx_dig: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(4);
        exp_v = {S_DONE, O_DONE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL lol_relink: got %h exp %h", w_obs, exp_v); else n_pass++;
    endtask

    task automatic test_abort;
        rx_is_lockedtodata = 4'b0111;
        tick(3);
        exp_v = {S_RX_ANA, O_RXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL abort_lol2: got %h exp %h", w_obs, exp_v); else n_pass++;
        rx_is_lockedtodata = 4'hF;
        tick(12);
        req_start = 1'b0;
        tick(1);
        exp_v = {S_IDLE, O_IDLE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL abort_idle: got %h exp %h", w_obs, exp_v); else n_pass++;
`ifdef HSSI_RST_SEQ_STATS_EN
        n_chk++;
        if (lol_cnt !== 16'd2) $display("FAIL stats_lol: got %0d exp 2", lol_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid;
        req_start = 1'b1;
        tick(1);
        exp_v = {S_INIT, O_INIT}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL rst_mid_init: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(10);
        exp_v = {S_TX_DIG, O_TXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL rst_mid_tx_dig: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        exp_v = {S_IDLE, O_IDLE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL rst_mid_idle: got %h exp %h", w_obs, exp_v); else n_pass++;
`ifdef HSSI_RST_SEQ_STATS_EN
        n_chk++;
        if (lol_cnt !== 16'd0) $display("FAIL stats_lol_clr: got %0d exp 0", lol_cnt); else n_pass++;
`endif
        rst_n = 1'b1;
        req_start = 1'b0;
    endtask

    task automatic test_tx_fail;
        tx_pll_locked = 1'b0;
        tick(3);
        req_start = 1'b1;
        tick(2);
        exp_v = {S_TX_ANA, O_TXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_tx_ana: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(8 + 199);
        exp_v = {S_TX_WAIT, O_TXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_wait_end: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_TX_ANA, O_TXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_retry1: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(208);
        exp_v = {S_TX_ANA, O_TXA}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_retry2: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(207);
        exp_v = {S_TX_WAIT, O_TXW}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_pre_fail: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(1);
        exp_v = {S_FAIL, O_FAIL}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_fail: got %h exp %h", w_obs, exp_v); else n_pass++;
        tick(5);
        exp_v = {S_FAIL, O_FAIL}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_sticky: got %h exp %h", w_obs, exp_v); else n_pass++;
`ifdef HSSI_RST_SEQ_STATS_EN
        n_chk++;
        if (retry_total !== 8'd3) $display("FAIL stats_retry: got %0d exp 3", retry_total); else n_pass++;
`endif
        req_start = 1'b0;
        tick(1);
        exp_v = {S_IDLE, O_IDLE}; n_chk++;
        if (w_obs !== exp_v) $display("FAIL txf_exit_idle: got %h exp %h", w_obs, exp_v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lol_glitch();
        test_abort();
        test_reset_mid();
        test_tx_fail();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
